// File: rtl/systolic_edge_feeder.sv
`default_nettype none
// ============================================================================
// Module      : systolic_edge_feeder
// Description : Skews a LANES-wide operand stream onto one systolic-array edge
//               and flags the first k-step of every tile with clr.
//               Optional stall counter enabled by macro FEEDER_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_edge_feeder #(
  parameter int IP_SIZE = 8,
  parameter int LANES   = 4,
  parameter int KW      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [KW-1:0]            k_len_i,
  output logic                     busy_o,
  output logic                     done_o,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  input  logic [LANES*IP_SIZE-1:0] s_data_i,
  output logic [LANES*IP_SIZE-1:0] x_out_o,
  output logic [LANES-1:0]         en_out_o,
  output logic [LANES-1:0]         clr_out_o,
  output logic [15:0]              stall_cnt_o
);

  localparam int            DW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [DW-1:0] DLAST = DW'(LANES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [KW-1:0] klen_q, klen_d;
  logic [KW-1:0] kcnt_q, kcnt_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          first_q, first_d;
  logic          done_q, done_d;
  logic          w_accept;

  assign s_ready_o = (state_q == ST_RUN);
  assign busy_o    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done_o    = done_q;
  assign w_accept  = s_valid_i & s_ready_o;

  always_comb begin
    state_d = state_q;
    klen_d  = klen_q;
    kcnt_d  = kcnt_q;
    dcnt_d  = dcnt_q;
    first_d = first_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (k_len_i != '0) begin
            state_d = ST_RUN;
            klen_d  = k_len_i;
            kcnt_d  = '0;
            first_d = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (w_accept) begin
          kcnt_d  = kcnt_q + KW'(1);
          first_d = 1'b0;
          // klen_q is never zero here, so the subtraction cannot wrap
          if (kcnt_q == klen_q - KW'(1)) begin
            state_d = ST_DRAIN;
            dcnt_d  = '0;
          end
        end
      end
      ST_DRAIN: begin
        dcnt_d = dcnt_q + DW'(1);
        if (dcnt_q == DLAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      klen_q  <= '0;
      kcnt_q  <= '0;
      dcnt_q  <= '0;
      first_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      klen_q  <= klen_d;
      kcnt_q  <= kcnt_d;
      dcnt_q  <= dcnt_d;
      first_q <= first_d;
      done_q  <= done_d;
    end
  end

  // Lane gi carries its own operand through gi+1 register stages
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic               en_q  [0:gi];
    logic               clr_q [0:gi];
    logic [IP_SIZE-1:0] x_q   [0:gi];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j <= gi; j++) begin
          en_q[j]  <= 1'b0;
          clr_q[j] <= 1'b0;
          x_q[j]   <= '0;
        end
      end else begin
        en_q[0]  <= w_accept;
        clr_q[0] <= w_accept & first_q;
        x_q[0]   <= w_accept ? s_data_i[gi*IP_SIZE +: IP_SIZE] : '0;
        for (int j = 1; j <= gi; j++) begin
          en_q[j]  <= en_q[j-1];
          clr_q[j] <= clr_q[j-1];
          x_q[j]   <= x_q[j-1];
        end
      end
    end

    assign en_out_o[gi]                     = en_q[gi];
    assign clr_out_o[gi]                    = clr_q[gi];
    assign x_out_o[gi*IP_SIZE +: IP_SIZE]   = x_q[gi];
  end

`ifdef FEEDER_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 16'h0;
    end else if ((state_q == ST_IDLE) && start_i) begin
      stall_q <= 16'h0;
    end else if ((state_q == ST_RUN) && !s_valid_i && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'h1;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = 16'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_systolic_edge_feeder.sv
`default_nettype none
// Directed bench for systolic_edge_feeder (LANES=4, IP_SIZE=8): table-driven
// cycle vectors plus hand sequences for k_len=0, mid-tile reset and stall count.
module tb_systolic_edge_feeder;

  localparam int IP_SIZE = 8;
  localparam int LANES   = 4;
  localparam int KW      = 16;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start_i;
  logic [KW-1:0]            k_len_i;
  logic                     busy_o;
  logic                     done_o;
  logic                     s_valid_i;
  logic                     s_ready_o;
  logic [LANES*IP_SIZE-1:0] s_data_i;
  logic [LANES*IP_SIZE-1:0] x_out_o;
  logic [LANES-1:0]         en_out_o;
  logic [LANES-1:0]         clr_out_o;
  logic [15:0]              stall_cnt_o;

  systolic_edge_feeder #(.IP_SIZE(IP_SIZE), .LANES(LANES), .KW(KW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .k_len_i     (k_len_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .s_valid_i   (s_valid_i),
    .s_ready_o   (s_ready_o),
    .s_data_i    (s_data_i),
    .x_out_o     (x_out_o),
    .en_out_o    (en_out_o),
    .clr_out_o   (clr_out_o),
    .stall_cnt_o (stall_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        start;
    logic [15:0] klen;
    logic        valid;
    logic [31:0] data;
    logic [3:0]  en;
    logic [3:0]  clr;
    logic [31:0] x;
    logic        busy;
    logic        rdy;
    logic        done;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic st, input logic [15:0] kl, input logic v,
                     input logic [31:0] d, input logic [3:0] e, input logic [3:0] c,
                     input logic [31:0] x, input logic b, input logic r, input logic dn);
    vec_t t;
    t.start = st; t.klen = kl; t.valid = v; t.data = d;
    t.en = e; t.clr = c; t.x = x; t.busy = b; t.rdy = r; t.done = dn;
    tbl.push_back(t);
  endtask

  localparam logic [31:0] P  = 32'h55555555;
  localparam logic [31:0] V1 = 32'h04030201;
  localparam logic [31:0] V2 = 32'h08070605;
  localparam logic [31:0] V3 = 32'hFFFEFDFC;
  localparam logic [31:0] T1 = 32'h0A0B0C0D;
  localparam logic [31:0] T2 = 32'h1A1B1C1D;
  localparam logic [31:0] T3 = 32'h7F800102;

  initial begin
    bit seen;
    int wait_n;
    logic [15:0] exp_stall;
    logic [8:0] vpat;

    rst = 1'b1; start_i = 1'b0; k_len_i = '0; s_valid_i = 1'b0; s_data_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_en",    {28'h0, en_out_o}, 32'h0);
    chk("rst_clr",   {28'h0, clr_out_o}, 32'h0);
    chk("rst_x",     x_out_o, 32'h0);
    chk("rst_busy",  {31'h0, busy_o}, 32'h0);
    chk("rst_done",  {31'h0, done_o}, 32'h0);
    chk("rst_ready", {31'h0, s_ready_o}, 32'h0);
    chk("rst_stall", {16'h0, stall_cnt_o}, 32'h0);
    rst = 1'b0;

    // Tile k_len=3, s_valid held high (ignored outside RUN)
    row(1, 3, 1, P,  4'b0000, 4'b0000, 32'h00000000, 0, 0, 0);
    row(0, 0, 1, V1, 4'b0000, 4'b0000, 32'h00000000, 1, 1, 0);
    row(0, 0, 1, V2, 4'b0001, 4'b0001, 32'h00000001, 1, 1, 0);
    row(0, 0, 1, V3, 4'b0011, 4'b0010, 32'h00000205, 1, 1, 0);
    row(0, 0, 1, P,  4'b0111, 4'b0100, 32'h000306FC, 1, 0, 0);
    row(0, 0, 1, P,  4'b1110, 4'b1000, 32'h0407FD00, 1, 0, 0);
    row(0, 0, 1, P,  4'b1100, 4'b0000, 32'h08FE0000, 1, 0, 0);
    row(0, 0, 1, P,  4'b1000, 4'b0000, 32'hFF000000, 1, 0, 0);
    row(0, 0, 1, P,  4'b0000, 4'b0000, 32'h00000000, 0, 0, 1);
    row(0, 0, 0, 0,  4'b0000, 4'b0000, 32'h00000000, 0, 0, 0);
    // Same tile with one bubble after the first vector
    row(1, 3, 0, 0,  4'b0000, 4'b0000, 32'h00000000, 0, 0, 0);
    row(0, 0, 1, V1, 4'b0000, 4'b0000, 32'h00000000, 1, 1, 0);
    row(0, 0, 0, V2, 4'b0001, 4'b0001, 32'h00000001, 1, 1, 0);
    row(0, 0, 1, V2, 4'b0010, 4'b0010, 32'h00000200, 1, 1, 0);
    row(0, 0, 1, V3, 4'b0101, 4'b0100, 32'h00030005, 1, 1, 0);
    row(0, 0, 0, 0,  4'b1011, 4'b1000, 32'h040006FC, 1, 0, 0);
    row(0, 0, 0, 0,  4'b0110, 4'b0000, 32'h0007FD00, 1, 0, 0);
    row(0, 0, 0, 0,  4'b1100, 4'b0000, 32'h08FE0000, 1, 0, 0);
    row(0, 0, 0, 0,  4'b1000, 4'b0000, 32'hFF000000, 1, 0, 0);
    row(0, 0, 0, 0,  4'b0000, 4'b0000, 32'h00000000, 0, 0, 1);
    row(0, 0, 0, 0,  4'b0000, 4'b0000, 32'h00000000, 0, 0, 0);
    // k_len=2 tile, then k_len=1 tile started in the done cycle
    row(1, 2, 0, 0,  4'b0000, 4'b0000, 32'h00000000, 0, 0, 0);
    row(0, 0, 1, T1, 4'b0000, 4'b0000, 32'h00000000, 1, 1, 0);
    row(0, 0, 1, T2, 4'b0001, 4'b0001, 32'h0000000D, 1, 1, 0);
    row(0, 0, 0, 0,  4'b0011, 4'b0010, 32'h00000C1D, 1, 0, 0);
    row(0, 0, 0, 0,  4'b0110, 4'b0100, 32'h000B1C00, 1, 0, 0);
    row(0, 0, 0, 0,  4'b1100, 4'b1000, 32'h0A1B0000, 1, 0, 0);
    row(0, 0, 0, 0,  4'b1000, 4'b0000, 32'h1A000000, 1, 0, 0);
    row(1, 1, 0, 0,  4'b0000, 4'b0000, 32'h00000000, 0, 0, 1);
    row(0, 0, 1, T3, 4'b0000, 4'b0000, 32'h00000000, 1, 1, 0);
    row(0, 0, 0, 0,  4'b0001, 4'b0001, 32'h00000002, 1, 0, 0);
    row(0, 0, 0, 0,  4'b0010, 4'b0010, 32'h00000100, 1, 0, 0);
    row(0, 0, 0, 0,  4'b0100, 4'b0100, 32'h00800000, 1, 0, 0);
    row(0, 0, 0, 0,  4'b1000, 4'b1000, 32'h7F000000, 1, 0, 0);
    row(0, 0, 0, 0,  4'b0000, 4'b0000, 32'h00000000, 0, 0, 1);
    row(0, 0, 0, 0,  4'b0000, 4'b0000, 32'h00000000, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      chk($sformatf("r%0d_en", i),    {28'h0, en_out_o},  {28'h0, tbl[i].en});
      chk($sformatf("r%0d_clr", i),   {28'h0, clr_out_o}, {28'h0, tbl[i].clr});
      chk($sformatf("r%0d_x", i),     x_out_o,            tbl[i].x);
      chk($sformatf("r%0d_busy", i),  {31'h0, busy_o},    {31'h0, tbl[i].busy});
      chk($sformatf("r%0d_ready", i), {31'h0, s_ready_o}, {31'h0, tbl[i].rdy});
      chk($sformatf("r%0d_done", i),  {31'h0, done_o},    {31'h0, tbl[i].done});
      start_i   = tbl[i].start;
      k_len_i   = tbl[i].klen;
      s_valid_i = tbl[i].valid;
      s_data_i  = tbl[i].data;
    end

    // k_len=0: no tile, done one cycle later
    @(negedge clk);
    start_i = 1'b1; k_len_i = 16'd0; s_valid_i = 1'b1; s_data_i = V1;
    @(negedge clk);
    start_i = 1'b0;
    chk("k0_busy", {31'h0, busy_o}, 32'h0);
    chk("k0_done", {31'h0, done_o}, 32'h1);
    chk("k0_en",   {28'h0, en_out_o}, 32'h0);
    @(negedge clk);
    s_valid_i = 1'b0;
    chk("k0_done_end", {31'h0, done_o}, 32'h0);
    chk("k0_en2",      {28'h0, en_out_o}, 32'h0);
    chk("k0_busy2",    {31'h0, busy_o}, 32'h0);

    // Reset during DRAIN
    start_i = 1'b1; k_len_i = 16'd2;
    @(negedge clk); start_i = 1'b0; s_valid_i = 1'b1; s_data_i = T1;
    @(negedge clk); s_data_i = T2;
    @(negedge clk); s_valid_i = 1'b0; s_data_i = '0;
    @(negedge clk);
    chk("rd_busy_pre", {31'h0, busy_o}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("rd_en",    {28'h0, en_out_o}, 32'h0);
    chk("rd_clr",   {28'h0, clr_out_o}, 32'h0);
    chk("rd_x",     x_out_o, 32'h0);
    chk("rd_busy",  {31'h0, busy_o}, 32'h0);
    chk("rd_ready", {31'h0, s_ready_o}, 32'h0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done_o === 1'b1 || en_out_o !== 4'b0) seen = 1'b1;
    end
    chk("rd_quiet", {31'h0, seen}, 32'h0);

    // k_len=4 with five stall cycles in RUN
`ifdef FEEDER_STALL_CNT_EN
    exp_stall = 16'd5;
`else
    exp_stall = 16'd0;
`endif
    vpat = 9'b101010010;
    start_i = 1'b1; k_len_i = 16'd4;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      s_valid_i = vpat[i];
      s_data_i  = V2;
      @(negedge clk);
    end
    s_valid_i = 1'b0;
    chk("st_drain", {31'h0, s_ready_o}, 32'h0);
    wait_n = 0;
    while (done_o !== 1'b1 && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    chk("st_done_seen", {31'h0, done_o}, 32'h1);
    chk("st_cnt",       {16'h0, stall_cnt_o}, {16'h0, exp_stall});
    repeat (3) @(negedge clk);
    chk("st_cnt_hold",  {16'h0, stall_cnt_o}, {16'h0, exp_stall});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
